// File: rtl/lc3_pkg.sv
// LC-3 control shared definitions.
// Opcodes, datapath encodings, FSM states, control bundle.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] EXT_IMM5 = 2'b00;
  localparam logic [1:0] EXT_OFF6 = 2'b01;
  localparam logic [1:0] EXT_PC9  = 2'b10;
  localparam logic [1:0] EXT_PC11 = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] ext;
    logic       reg_write;
    logic       sr2_mux;
    logic       dr_mux;
    logic       srpc_mux;
    logic       br_mux;
    logic       imm_sr2_mux;
    logic       jmp_mux;
    logic       mem;
    logic       store;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    if (op == OP_AND) return ALU_AND;
    if (op == OP_NOT) return ALU_NOT;
    return ALU_ADD;
  endfunction

endpackage

// File: rtl/lc3_decode.sv
// LC-3 instruction decoder.
// Pure combinational map from IR to the control bundle.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        trap
);

  logic [3:0] op;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign unused_ir = ^{ir[10:6], ir[4:0]};

  // Opcode to datapath controls; unsupported ops yield no controls
  always_comb begin
    ctrl    = CTRL_NONE;
    illegal = 1'b0;
    trap    = 1'b0;
    unique case (op)
      OP_ADD, OP_AND, OP_NOT: begin
        ctrl.alu         = alu_sel(op);
        ctrl.srpc_mux    = 1'b1;
        ctrl.imm_sr2_mux = ~ir[5];
        ctrl.br_mux      = ir[5];
        ctrl.reg_write   = 1'b1;
      end
      OP_BR: begin
        ctrl.ext     = EXT_PC9;
        ctrl.br_mux  = 1'b1;
        ctrl.jmp_mux = 1'b1;
      end
      OP_JMP: begin
        ctrl.srpc_mux = 1'b1;
        ctrl.jmp_mux  = 1'b1;
      end
      OP_JSR: begin
        ctrl.dr_mux    = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jmp_mux   = 1'b1;
        if (ir[11]) begin
          ctrl.ext    = EXT_PC11;
          ctrl.br_mux = 1'b1;
        end else begin
          ctrl.srpc_mux = 1'b1;
        end
      end
      OP_LEA: begin
        ctrl.ext       = EXT_PC9;
        ctrl.br_mux    = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LD, OP_ST: begin
        ctrl.ext     = EXT_PC9;
        ctrl.br_mux  = 1'b1;
        ctrl.mem     = 1'b1;
        ctrl.store   = (op == OP_ST);
        ctrl.sr2_mux = (op == OP_ST);
      end
      OP_LDR, OP_STR: begin
        ctrl.ext      = EXT_OFF6;
        ctrl.srpc_mux = 1'b1;
        ctrl.br_mux   = 1'b1;
        ctrl.mem      = 1'b1;
        ctrl.store    = (op == OP_STR);
        ctrl.sr2_mux  = (op == OP_STR);
      end
      OP_TRAP: trap = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lc3_control.sv
// LC-3 multi-cycle control sequencer.
// Fetch, decode and drive datapath one instruction at a time.
module lc3_control
  import lc3_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rams_output,
  input  logic        ram_ready,
  output logic [15:0] instruction,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ExtByHowMuch,
  output logic        RegWrite,
  output logic        PtrToPtr,
  output logic        SR2Mux,
  output logic        DRMux,
  output logic        RegWriteMux,
  output logic        SRPCMux,
  output logic        BrMux,
  output logic        ImmSR2Mux,
  output logic        JMPMux,
  output logic        pc_we,
  output logic        ram_req,
  output logic        ram_we,
  output logic        ram_addr_sel,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir_q;
  logic [15:0] retired_q;
  logic        illegal_q;
  ctrl_t       ctrl;
  ctrl_t       held;
  logic        dec_illegal;
  logic        dec_trap;
  logic        req;
  logic        halt_illegal;

  lc3_decode u_decode (
    .ir      (ir_q),
    .ctrl    (ctrl),
    .illegal (dec_illegal),
    .trap    (dec_trap)
  );

  // State, IR, retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && ram_ready) ir_q <= rams_output;
      if (pc_we) retired_q <= retired_q + 16'd1;
      if (halt_illegal) illegal_q <= 1'b1;
    end
  end

  // Next state, strobes and state-gated controls
  always_comb begin
    state_nx     = state;
    held         = CTRL_NONE;
    RegWrite     = 1'b0;
    RegWriteMux  = 1'b0;
    pc_we        = 1'b0;
    req          = 1'b0;
    ram_we       = 1'b0;
    ram_addr_sel = 1'b0;
    halt_illegal = 1'b0;
    unique case (state)
      S_FETCH: begin
        req = 1'b1;
        if (ram_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        held = ctrl;
        if (dec_trap) begin
          state_nx = S_HALT;
        end else if (dec_illegal && HALT_ON_ILLEGAL != 0) begin
          state_nx     = S_HALT;
          halt_illegal = 1'b1;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        held = ctrl;
        if (ctrl.mem) begin
          state_nx = S_MEM;
        end else begin
          RegWrite = ctrl.reg_write;
          pc_we    = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_MEM: begin
        held         = ctrl;
        req          = 1'b1;
        ram_addr_sel = 1'b1;
        ram_we       = ctrl.store;
        if (ram_ready) begin
          if (ctrl.store) begin
            pc_we    = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        held        = ctrl;
        RegWrite    = 1'b1;
        RegWriteMux = 1'b1;
        pc_we       = 1'b1;
        state_nx    = S_FETCH;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Reset must kill a pending request without waiting for a clock
  assign ram_req      = req & rst_n;
  assign instruction  = ir_q;
  assign ALUControl   = held.alu;
  assign ExtByHowMuch = held.ext;
  assign SR2Mux       = held.sr2_mux;
  assign DRMux        = held.dr_mux;
  assign SRPCMux      = held.srpc_mux;
  assign BrMux        = held.br_mux;
  assign ImmSR2Mux    = held.imm_sr2_mux;
  assign JMPMux       = held.jmp_mux;
  assign PtrToPtr     = 1'b0;
  assign halted       = (state == S_HALT);
  assign illegal      = illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control.
// Vector table for single instructions plus hand sequences.
module tb_lc3_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rams_output = '0;
  logic        ram_ready = 1'b0;
  logic [15:0] instruction;
  logic [1:0]  ALUControl;
  logic [1:0]  ExtByHowMuch;
  logic        RegWrite, PtrToPtr, SR2Mux, DRMux, RegWriteMux;
  logic        SRPCMux, BrMux, ImmSR2Mux, JMPMux;
  logic        pc_we, ram_req, ram_we, ram_addr_sel;
  logic        halted, illegal;
  logic [15:0] retired;

  int          n_run = 0;
  int          n_fail = 0;
  logic [15:0] exp_ret = '0;

  lc3_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rams_output  (rams_output),
    .ram_ready    (ram_ready),
    .instruction  (instruction),
    .ALUControl   (ALUControl),
    .ExtByHowMuch (ExtByHowMuch),
    .RegWrite     (RegWrite),
    .PtrToPtr     (PtrToPtr),
    .SR2Mux       (SR2Mux),
    .DRMux        (DRMux),
    .RegWriteMux  (RegWriteMux),
    .SRPCMux      (SRPCMux),
    .BrMux        (BrMux),
    .ImmSR2Mux    (ImmSR2Mux),
    .JMPMux       (JMPMux),
    .pc_we        (pc_we),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_addr_sel (ram_addr_sel),
    .halted       (halted),
    .illegal      (illegal),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] ir;
    int          lat;
    logic [1:0]  alu;
    logic [1:0]  ext;
    logic [6:0]  flags;
    int          rw;
    logic        st;
    int          wait_n;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [10:0] ctl_now();
    return {ALUControl, ExtByHowMuch, RegWrite, SR2Mux, DRMux,
            SRPCMux, BrMux, ImmSR2Mux, JMPMux};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_instr(
    input  logic [15:0] ir,
    input  int          wait_n,
    output int          lat,
    output logic [10:0] ctl3,
    output int          rw_n,
    output logic [15:0] ir_dec,
    output logic        st_seen,
    output logic        wait_ok,
    output logic        wbmux
  );
    int cyc = 0;
    int pc_n = 0;
    lat = 0; ctl3 = '0; rw_n = 0; ir_dec = '0;
    st_seen = 1'b0; wait_ok = 1'b1; wbmux = 1'b0;
    while (pc_n == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      rams_output = ir;
      ram_ready = (cyc >= 4 && cyc < 4 + wait_n) ? 1'b0 : 1'b1;
      #1;
      if (cyc == 2) ir_dec = instruction;
      if (cyc == 3) ctl3 = ctl_now();
      if (ram_req && ram_addr_sel && ram_we) st_seen = 1'b1;
      if (cyc >= 4 && cyc < 4 + wait_n)
        if (!(ram_req && ram_addr_sel && ctl_now() == ctl3))
          wait_ok = 1'b0;
      if (RegWrite) rw_n++;
      if (pc_we) begin
        pc_n++;
        lat = cyc;
        wbmux = RegWriteMux;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ram_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
  endtask

  initial begin
    int          lat, rw_n;
    logic [10:0] ctl3;
    logic [15:0] ir_dec;
    logic        st_seen, wait_ok, wbmux;
    int          bad;

    //             ir      lat alu    ext    RW SR2 DR SRPC Br Imm JMP  rw st wait
    tbl[0]  = '{16'h1261, 3, 2'b00, 2'b00, 7'b1001100, 1, 1'b0, 0};
    tbl[1]  = '{16'h1042, 3, 2'b00, 2'b00, 7'b1001010, 1, 1'b0, 0};
    tbl[2]  = '{16'h5260, 3, 2'b01, 2'b00, 7'b1001100, 1, 1'b0, 0};
    tbl[3]  = '{16'h927F, 3, 2'b10, 2'b00, 7'b1001100, 1, 1'b0, 0};
    tbl[4]  = '{16'h0E05, 3, 2'b00, 2'b10, 7'b0000101, 0, 1'b0, 0};
    tbl[5]  = '{16'hC1C0, 3, 2'b00, 2'b00, 7'b0001001, 0, 1'b0, 0};
    tbl[6]  = '{16'h4805, 3, 2'b00, 2'b11, 7'b1010101, 1, 1'b0, 0};
    tbl[7]  = '{16'h4080, 3, 2'b00, 2'b00, 7'b1011001, 1, 1'b0, 0};
    tbl[8]  = '{16'hE405, 3, 2'b00, 2'b10, 7'b1000100, 1, 1'b0, 0};
    tbl[9]  = '{16'h2203, 5, 2'b00, 2'b10, 7'b0000100, 1, 1'b0, 0};
    tbl[10] = '{16'h3203, 4, 2'b00, 2'b10, 7'b0100100, 0, 1'b1, 0};
    tbl[11] = '{16'h6285, 5, 2'b00, 2'b01, 7'b0001100, 1, 1'b0, 0};
    tbl[12] = '{16'h7285, 4, 2'b00, 2'b01, 7'b0101100, 0, 1'b1, 0};
    tbl[13] = '{16'h6285, 9, 2'b00, 2'b01, 7'b0001100, 1, 1'b0, 4};
    tbl[14] = '{16'h7285, 6, 2'b00, 2'b01, 7'b0101100, 0, 1'b1, 2};

    // Reset state, with a stray ram_ready that must be ignored
    @(negedge clk);
    ram_ready = 1'b1;
    @(negedge clk);
    #1;
    check("reset_outputs", 32'({instruction, ctl_now(), PtrToPtr,
          RegWriteMux, pc_we, ram_req, ram_we, ram_addr_sel,
          halted, illegal}), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_ready = 1'b0;
    #1;
    check("fetch_after_reset", 32'({ram_req, ram_addr_sel, ram_we}),
          32'(3'b100));

    for (int i = 0; i < 15; i++) begin
      run_instr(tbl[i].ir, tbl[i].wait_n, lat, ctl3, rw_n, ir_dec,
                st_seen, wait_ok, wbmux);
      check($sformatf("v%0d_ctl", i), 32'(ctl3),
            32'({tbl[i].alu, tbl[i].ext, tbl[i].flags}));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("v%0d_regwrite", i), 32'(rw_n), 32'(tbl[i].rw));
      check($sformatf("v%0d_ram_we", i), 32'(st_seen), 32'(tbl[i].st));
      check($sformatf("v%0d_ir", i), 32'(ir_dec), 32'(tbl[i].ir));
      if (tbl[i].ir[15:12] == 4'h2 || tbl[i].ir[15:12] == 4'h6)
        check($sformatf("v%0d_wbmux", i), 32'(wbmux), 32'd1);
      if (tbl[i].wait_n > 0)
        check($sformatf("v%0d_mem_hold", i), 32'(wait_ok), 32'd1);
      exp_ret = exp_ret + 16'd1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_retired", i), 32'(retired), 32'(exp_ret));
    end

    // Reset in the middle of a MEM wait
    @(negedge clk); rams_output = 16'h6285; ram_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); ram_ready = 1'b0;
    #1;
    check("mem_wait_req", 32'({ram_req, ram_addr_sel}), 32'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(ram_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = '0;
    #1;
    check("restart_fetch", 32'({ram_req, ram_addr_sel}), 32'(2'b10));
    check("restart_retired", 32'(retired), 32'(exp_ret));

    // Counter wrap: start from FFFF, retire one NOP
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    run_instr(16'h0000, 0, lat, ctl3, rw_n, ir_dec, st_seen,
              wait_ok, wbmux);
    check("nop_lat", 32'(lat), 32'd3);
    exp_ret = exp_ret + 16'd1;
    @(posedge clk);
    #1;
    check("retired_wrap", 32'(retired), 32'(exp_ret));

    // TRAP halts without flagging illegal
    @(negedge clk); rams_output = 16'hF025; ram_ready = 1'b1;
    @(negedge clk); #1;
    check("trap_ir", 32'(instruction), 32'h0000F025);
    @(negedge clk); #1;
    check("trap_halt", 32'({halted, illegal}), 32'(2'b10));
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ram_ready = i[0];
      #1;
      if (ram_req || pc_we || RegWrite || !halted) bad++;
    end
    check("halt_absorbing", 32'(bad), 32'd0);
    check("halt_retired", 32'(retired), 32'(exp_ret));

    // Reserved opcode halts and sets the sticky flag
    do_reset();
    #1;
    check("reset_clears_halt", 32'({halted, illegal}), 32'd0);
    @(negedge clk); rams_output = 16'hD000; ram_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("illegal_halt", 32'({halted, illegal}), 32'(2'b11));
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ram_ready = 1'b1;
      #1;
      if (ram_req || pc_we || !illegal) bad++;
    end
    check("illegal_sticky", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
